// File: rtl/tcam_update_ctrl_pkg.sv
// Shared types and constants for the TCAM update front end.
// Pure declarations: no logic, no latency, no flow control.
package tcam_update_ctrl_pkg;

  localparam int GROUP_SIZE  = 8;
  localparam int CHUNK_WIDTH = 5;

  localparam logic OP_DELETE = 1'b0;
  localparam logic OP_WRITE  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_ARM,
    ST_HOLD,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/tcam_shadow_ram.sv
// Shadow copy of the rule groups: one {keep, data} group per word, simple dual port.
// Read data appears one cycle after rd_en; always accepts reads and writes, no stall.
module tcam_shadow_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 640,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tcam_update_ctrl.sv
// Single-rule write/delete front end: rebuilds the 8-rule group and drives the group-update engine.
// Handshake to wr_enable is 3 cycles; s_req_ready stays low until the engine finishes or times out.
module tcam_update_ctrl
  import tcam_update_ctrl_pkg::*;
#(
  parameter int TCAM_DEPTH       = 512,
  parameter int TCAM_WIDTH       = 40,
  parameter int GROUP_ADDR_WIDTH = $clog2(TCAM_DEPTH / 8),
  parameter int ADDR_WIDTH       = $clog2(TCAM_DEPTH),
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_req_valid,
  output logic                             s_req_ready,
  input  logic                             s_req_op,
  input  logic [ADDR_WIDTH-1:0]            s_req_addr,
  input  logic [TCAM_WIDTH-1:0]            s_req_data,
  input  logic [TCAM_WIDTH-1:0]            s_req_keep,
  output logic                             resp_valid,
  output logic                             resp_err,
  output logic [TCAM_WIDTH*GROUP_SIZE-1:0] wr_tcam_data,
  output logic [TCAM_WIDTH*GROUP_SIZE-1:0] wr_tcam_keep,
  output logic                             wr_enable,
  output logic [GROUP_ADDR_WIDTH-1:0]      wr_enable_sel,
  input  logic                             wr_busy,
  output logic [TCAM_DEPTH-1:0]            rule_valid,
  output logic                             update_active
);

  localparam int GROUPS = TCAM_DEPTH / GROUP_SIZE;
  localparam int GW     = GROUP_SIZE * TCAM_WIDTH;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                      state;
  logic                        req_op;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic [TCAM_WIDTH-1:0]       req_data;
  logic [TCAM_WIDTH-1:0]       req_keep;
  logic [GROUP_ADDR_WIDTH-1:0] req_group;
  logic [TW-1:0]               wdog;

  logic                        req_fire;
  logic                        ram_wr_en;
  logic [2*GW-1:0]             ram_rd_data;
  logic [GW-1:0]               merged_data;
  logic [GW-1:0]               merged_keep;
  logic                        wdog_expired;

  assign req_fire      = s_req_valid & s_req_ready;
  assign req_group     = req_addr[ADDR_WIDTH-1:3];
  assign ram_wr_en     = (state == ST_MERGE);
  assign wdog_expired  = (wdog == TIMEOUT_LAST);
  assign update_active = wr_enable | wr_busy;

  // Read is launched straight from the request port so data is ready in READ.
  tcam_shadow_ram #(
    .DEPTH (GROUPS),
    .WIDTH (2 * GW),
    .AW    (GROUP_ADDR_WIDTH)
  ) u_shadow (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (req_group),
    .wr_data ({merged_keep, merged_data}),
    .rd_en   (req_fire),
    .rd_addr (s_req_addr[ADDR_WIDTH-1:3]),
    .rd_data (ram_rd_data)
  );

  // Slots whose rule is not valid are emitted as zero, so stale shadow
  // contents left over from before a reset never reach the engine.
  always_comb begin
    merged_data = '0;
    merged_keep = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      if (3'(k) == req_addr[2:0]) begin
        if (req_op == OP_WRITE) begin
          merged_data[k*TCAM_WIDTH +: TCAM_WIDTH] = req_data;
          merged_keep[k*TCAM_WIDTH +: TCAM_WIDTH] = req_keep;
        end
      end else if (rule_valid[{req_group, 3'(k)}]) begin
        merged_data[k*TCAM_WIDTH +: TCAM_WIDTH] = ram_rd_data[k*TCAM_WIDTH +: TCAM_WIDTH];
        merged_keep[k*TCAM_WIDTH +: TCAM_WIDTH] = ram_rd_data[GW + k*TCAM_WIDTH +: TCAM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      s_req_ready   <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      wr_enable     <= 1'b0;
      wr_enable_sel <= '0;
      wr_tcam_data  <= '0;
      wr_tcam_keep  <= '0;
      rule_valid    <= '0;
      wdog          <= '0;
      req_op        <= 1'b0;
      req_addr      <= '0;
      req_data      <= '0;
      req_keep      <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          s_req_ready <= 1'b1;
          if (req_fire) begin
            req_op      <= s_req_op;
            req_addr    <= s_req_addr;
            req_data    <= s_req_data;
            req_keep    <= s_req_keep;
            s_req_ready <= 1'b0;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          state <= ST_MERGE;
        end
        ST_MERGE: begin
          wr_tcam_data         <= merged_data;
          wr_tcam_keep         <= merged_keep;
          wr_enable_sel        <= req_group;
          rule_valid[req_addr] <= req_op;
          wdog                 <= '0;
          wr_enable            <= 1'b1;
          state                <= ST_ARM;
        end
        ST_ARM: begin
          wdog <= wdog + 1'b1;
          if (wdog_expired) begin
            wr_enable  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= ST_RELEASE;
          end else if (wr_busy) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Dropping wr_enable early would make the engine restart its sequence.
          wdog <= wdog + 1'b1;
          if (wdog_expired) begin
            wr_enable  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= ST_RELEASE;
          end else if (!wr_busy) begin
            wr_enable  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          s_req_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          s_req_ready <= 1'b0;
          wr_enable   <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
